avr_tick_sched: RTL and testbench
=================================

// Module: avr_tick_sched
// PURPOSE
//  Multi-channel software-alarm scheduler driven by the systick tick pulse.
//  Shares one systick among NCH alarm channels; each channel has an 8-bit reload and is one-shot or periodic.
//  Merges the channels' expiries into one prioritised IRQ with a channel id and acknowledge.
//  Sits on the AVR I/O bus beside the systick; its irq output feeds the core interrupt input.
// PARAMETERS
//  NCH   4   number of alarm channels, 1..4; unused channel bits read 0 and ignore writes
// PORTS
//  clk      in   1  system clock; single clock domain
//  rst      in   1  synchronous reset, active-low (0 = reset), sampled on posedge clk
//  tick     in   1  one-cycle tick pulse from systick overflow
//  io_re    in   1  I/O read strobe
//  io_we    in   1  I/O write strobe
//  io_a     in   3  register address
//  io_di    in   8  write data
//  io_do    out  8  read data; 8'h00 when io_re=0
//  irq      out  1  interrupt request = |(PEND & IMASK)
//  irq_id   out  2  lowest-index channel with PEND&IMASK set; 0 when irq=0
//  irq_ack  in   1  one-cycle acknowledge; clears PEND[irq_id] as sampled in the same cycle
// BEHAVIOUR
//  Register map:
//   0 ENABLE  rw  {4'b0,EN[3:0]}
//   1 MODE    rw  {4'b0,PER[3:0]}; 1 = periodic, 0 = one-shot
//   2 STATUS  r/w1c  {OVR[3:0],PEND[3:0]}
//   3 IMASK   rw  {PSC[3:0] (macro only, else 0), IM[3:0]}
//   4..7 RELOADn  rw  8-bit reload value of channel n = io_a-4
//  Reset: EN=0, PER=0, PEND=0, OVR=0, IM=0, PSC=0, RELOAD=8'hFF, CNT=0, prescale count=0;
//   irq=0, irq_id=0, io_do=0.
//  All register writes take effect on the clk edge where io_we=1; a write with io_re=1 is ignored.
//  Enable:
//   - ENABLE write taking EN[n] 0->1 loads CNT[n]<=RELOAD[n] at that edge.
//   - Writing EN 1->1 does not reload.
//   - EN 1->0 freezes CNT[n]; PEND/OVR are kept.
//  Counting: on an effective tick with EN[n]=1:
//   - CNT[n]!=0: CNT[n]<=CNT[n]-1.
//   - CNT[n]==0 (expiry): PEND[n]<=1; OVR[n]<=1 if PEND[n] was already 1.
//     If PER[n]=1: CNT[n]<=RELOAD[n]. If PER[n]=0: EN[n]<=0.
//   - Period = RELOAD+1 ticks. RELOAD=0 gives expiry on every tick.
//  RELOAD write while running: no effect on CNT until the next reload/enable.
//  Latency: tick in cycle N -> PEND/irq/irq_id valid from cycle N+1. irq/irq_id are combinational from registers.
//  Arbitration: fixed priority, channel 0 highest. irq_id changes as soon as the higher channel's PEND sets.
//  Simultaneous events on one channel in one cycle:
//   - Expiry set beats irq_ack clear and beats STATUS W1C clear; PEND stays 1 and OVR is set.
//   - Enable 0->1 write coinciding with a tick loads RELOAD; that tick does not decrement or expire.
//   - ENABLE write clearing EN[n] in the same cycle as expiry: the write wins (EN=0); PEND still sets.
//  irq_ack with irq=0: no effect. Ack and W1C of different channels in one cycle: both apply.
//  Reset asserted mid-count: all state returns to reset values at that edge; tick is ignored while rst=0.
// CONFIGURATION
//  Macro: TICKSCHED_PRESCALE_EN.
//   - Defined: IMASK[7:4]=PSC (rw). A 4-bit prescale counter passes every (PSC+1)th tick as the effective tick.
//     The prescaler counts tick pulses only; writing PSC clears the prescale counter.
//     The first effective tick after a PSC write is the (PSC+1)th tick pulse.
//   - Undefined: IMASK[7:4] reads 0, writes are ignored, and every tick is effective.
// TESTING
//  1. rst=0 for 2 clk, then read all 8 addresses -> 00,00,00,00,FF,FF,FF,FF; irq=0.
//  2. RELOAD0=3, PER0=1, IM0=1, EN0=1, then 8 ticks -> PEND0 sets after ticks 4 and 8; irq the cycle after each;
//     W1C STATUS=01 between expiries clears it; OVR0=0.
//  3. RELOAD1=0, one-shot, EN1=1, no clear, 2 ticks -> PEND1=1 after tick 1; EN1 reads 0 after tick 1;
//     OVR1=0; second tick has no effect.
//  4. Ch0 and ch2 expire on the same tick, IM=05 -> irq_id=0; irq_ack -> irq_id=2, irq=1; irq_ack -> irq=0.
//  5. PEND0=1, periodic RELOAD0=0, irq_ack in the same cycle as an effective tick -> PEND0 stays 1, OVR0=1.
//  6. TICKSCHED_PRESCALE_EN defined, PSC=2, RELOAD0=1, EN0=1 -> first PEND0 after tick 6;
//     undefined build -> after tick 2, and IMASK readback of written F1 = 01.

Source files
------------

// File: rtl/avr_tick_sched_if.sv
// Bus bundle between the AVR I/O bus / systick / core IRQ input and avr_tick_sched.
// Latency: wires only, no storage.
// Backpressure: none; strobes are single-cycle and always accepted.
interface avr_tick_sched_if;
  logic       tick;
  logic       io_re;
  logic       io_we;
  logic [2:0] io_a;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic       irq;
  logic [1:0] irq_id;
  logic       irq_ack;

  // Core/bus side: drives strobes, tick and acknowledge; observes read data and IRQ.
  modport master (
    output tick, io_re, io_we, io_a, io_di, irq_ack,
    input  io_do, irq, irq_id
  );

  // Scheduler side.
  modport slave (
    input  tick, io_re, io_we, io_a, io_di, irq_ack,
    output io_do, irq, irq_id
  );
endinterface

// File: rtl/avr_tick_sched.sv
// Multi-channel alarm scheduler on the systick tick; merges expiries into one prioritised IRQ.
// Latency: tick in cycle N -> PEND/irq/irq_id visible in N+1; register writes land on the write edge.
// Backpressure: none; every strobe, tick and ack is consumed in its cycle. Option macro: TICKSCHED_PRESCALE_EN.
module avr_tick_sched #(
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rst,
  avr_tick_sched_if.slave  bus
);

  localparam logic [3:0] CH_MASK = 4'((1 << NCH) - 1);

  logic [3:0] r_en, r_per, r_pend, r_ovr, r_im;
  logic [7:0] r_reload [4];
  logic [7:0] r_cnt    [4];

  logic       w_wr, w_wr_en, w_wr_mode, w_wr_stat, w_wr_imask, w_wr_rld;
  logic       w_etick, w_irq;
  logic [1:0] w_irq_id;
  logic [3:0] w_act, w_exp, w_load, w_en_nxt, w_ack_clr, w_w1c_pend, w_w1c_ovr, w_psc;
  logic [7:0] w_rdata;

  // A write that coincides with a read is dropped entirely.
  assign w_wr       = bus.io_we & ~bus.io_re;
  assign w_wr_en    = w_wr & (bus.io_a == 3'd0);
  assign w_wr_mode  = w_wr & (bus.io_a == 3'd1);
  assign w_wr_stat  = w_wr & (bus.io_a == 3'd2);
  assign w_wr_imask = w_wr & (bus.io_a == 3'd3);
  assign w_wr_rld   = w_wr & bus.io_a[2];

`ifdef TICKSCHED_PRESCALE_EN
  logic [3:0] r_psc, r_pscnt;

  // A PSC write restarts the divider, so the tick of that same cycle is not counted.
  assign w_etick = bus.tick & (r_pscnt == r_psc) & ~w_wr_imask;
  assign w_psc   = r_psc;

  // Prescaler: pass every (PSC+1)th tick pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_psc   <= 4'd0;
      r_pscnt <= 4'd0;
    end else if (w_wr_imask) begin
      r_psc   <= bus.io_di[7:4];
      r_pscnt <= 4'd0;
    end else if (bus.tick) begin
      r_pscnt <= (r_pscnt == r_psc) ? 4'd0 : r_pscnt + 4'd1;
    end
  end
`else
  assign w_etick = bus.tick;
  assign w_psc   = 4'd0;
`endif

  // Per-channel expiry/load decode; an ENABLE write always decides the new EN value.
  always_comb begin
    w_exp = 4'd0;
    for (int n = 0; n < 4; n++) begin
      w_exp[n] = w_etick & r_en[n] & (r_cnt[n] == 8'd0) & CH_MASK[n];
    end
    w_load     = {4{w_wr_en}} & bus.io_di[3:0] & ~r_en & CH_MASK;
    w_en_nxt   = w_wr_en ? (bus.io_di[3:0] & CH_MASK) : (r_en & ~(w_exp & ~r_per));
    w_ack_clr  = (bus.irq_ack & w_irq) ? (4'd1 << w_irq_id) : 4'd0;
    w_w1c_pend = w_wr_stat ? bus.io_di[3:0] : 4'd0;
    w_w1c_ovr  = w_wr_stat ? bus.io_di[7:4] : 4'd0;
  end

  // Fixed-priority arbitration, channel 0 highest.
  always_comb begin
    w_act    = r_pend & r_im;
    w_irq    = |w_act;
    w_irq_id = 2'd0;
    if      (w_act[0]) w_irq_id = 2'd0;
    else if (w_act[1]) w_irq_id = 2'd1;
    else if (w_act[2]) w_irq_id = 2'd2;
    else if (w_act[3]) w_irq_id = 2'd3;
  end

  // Control/status registers; an expiry set outranks ack and W1C clears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en   <= 4'd0;
      r_per  <= 4'd0;
      r_pend <= 4'd0;
      r_ovr  <= 4'd0;
      r_im   <= 4'd0;
    end else begin
      r_en   <= w_en_nxt;
      if (w_wr_mode)  r_per <= bus.io_di[3:0] & CH_MASK;
      if (w_wr_imask) r_im  <= bus.io_di[3:0] & CH_MASK;
      r_pend <= (w_exp | (r_pend & ~(w_ack_clr | w_w1c_pend))) & CH_MASK;
      r_ovr  <= ((w_exp & r_pend) | (r_ovr & ~w_w1c_ovr)) & CH_MASK;
    end
  end

  // Reload values and down-counters; a reload write never touches a running count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 4; n++) begin
        r_reload[n] <= 8'hFF;
        r_cnt[n]    <= 8'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_wr_rld && (bus.io_a[1:0] == 2'(n)) && CH_MASK[n]) r_reload[n] <= bus.io_di;
        if (w_load[n]) begin
          r_cnt[n] <= r_reload[n];
        end else if (r_en[n] && w_etick) begin
          if (r_cnt[n] != 8'd0)  r_cnt[n] <= r_cnt[n] - 8'd1;
          else if (r_per[n])     r_cnt[n] <= r_reload[n];
        end
      end
    end
  end

  // Read mux; bus is driven to zero whenever no read is in progress.
  always_comb begin
    w_rdata = 8'h00;
    case (bus.io_a)
      3'd0:    w_rdata = {4'b0, r_en};
      3'd1:    w_rdata = {4'b0, r_per};
      3'd2:    w_rdata = {r_ovr, r_pend};
      3'd3:    w_rdata = {w_psc, r_im};
      default: w_rdata = CH_MASK[bus.io_a[1:0]] ? r_reload[bus.io_a[1:0]] : 8'h00;
    endcase
  end

  assign bus.io_do  = bus.io_re ? w_rdata : 8'h00;
  assign bus.irq    = w_irq;
  assign bus.irq_id = w_irq_id;

endmodule

// File: tb/tb_avr_tick_sched.sv
// Scoreboard bench for avr_tick_sched: reads push expected {io_do,irq,irq_id}; a negedge monitor checks.
// Latency: expectations are checked in the same cycle the read strobe is presented.
// Backpressure: none; stimulus is a fixed directed sequence.
module tb_avr_tick_sched;

`ifdef TICKSCHED_PRESCALE_EN
  localparam logic [7:0] IMASK_F1 = 8'hF1;
  localparam logic [7:0] IMASK_21 = 8'h21;
  localparam int         FIRST_EXP = 6;
`else
  localparam logic [7:0] IMASK_F1 = 8'h01;
  localparam logic [7:0] IMASK_21 = 8'h01;
  localparam int         FIRST_EXP = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avr_tick_sched_if bus ();

  avr_tick_sched #(.NCH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic       irq;
    logic [1:0] id;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compare every presented read against the next expectation; idle bus must read 0.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.io_re) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: got do=%02h irq=%0d id=%0d, required no read", bus.io_do, bus.irq, bus.irq_id);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.io_do !== e.d || bus.irq !== e.irq || bus.irq_id !== e.id) begin
            n_fail++;
            $display("FAIL %s: got do=%02h irq=%0d id=%0d, required do=%02h irq=%0d id=%0d",
                     e.nm, bus.io_do, bus.irq, bus.irq_id, e.d, e.irq, e.id);
          end
        end
      end else begin
        n_tests++;
        if (bus.io_do !== 8'h00) begin
          n_fail++;
          $display("FAIL io_do_idle: got %02h, required 00", bus.io_do);
        end
      end
    end
  end

  task automatic cyc(input logic re, input logic we, input logic [2:0] a, input logic [7:0] di,
                     input logic tk, input logic ak);
    bus.io_re = re; bus.io_we = we; bus.io_a = a; bus.io_di = di;
    bus.tick = tk; bus.irq_ack = ak;
    @(posedge clk); #1;
    bus.io_re = 1'b0; bus.io_we = 1'b0; bus.io_a = 3'd0; bus.io_di = 8'h00;
    bus.tick = 1'b0; bus.irq_ack = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic ack();
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic expect_rd(input string nm, input logic [7:0] d, input logic irq, input logic [1:0] id);
    exp_t e;
    e.nm = nm; e.d = d; e.irq = irq; e.id = id;
    q.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [7:0] d,
                    input logic irq, input logic [1:0] id);
    expect_rd(nm, d, irq, id);
    cyc(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] reset_vals [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    bus.io_re = 1'b0; bus.io_we = 1'b0; bus.io_a = 3'd0; bus.io_di = 8'h00;
    bus.tick = 1'b0; bus.irq_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) rd($sformatf("reset_reg%0d", i), 3'(i), reset_vals[i], 1'b0, 2'd0);

    // Periodic channel 0, reload 3: expiry on ticks 4 and 8
    wr(3'd4, 8'd3); wr(3'd1, 8'h01); wr(3'd3, 8'h01); wr(3'd0, 8'h01);
    rd("per_en_rd", 3'd0, 8'h01, 1'b0, 2'd0);
    repeat (3) tick();
    rd("per_t3", 3'd2, 8'h00, 1'b0, 2'd0);
    tick();
    rd("per_t4", 3'd2, 8'h01, 1'b1, 2'd0);
    wr(3'd2, 8'h01);
    rd("per_w1c", 3'd2, 8'h00, 1'b0, 2'd0);
    repeat (3) tick();
    rd("per_t7", 3'd2, 8'h00, 1'b0, 2'd0);
    tick();
    rd("per_t8", 3'd2, 8'h01, 1'b1, 2'd0);
    wr(3'd0, 8'h00); wr(3'd2, 8'hFF);
    rd("per_clr", 3'd2, 8'h00, 1'b0, 2'd0);

    // One-shot channel 1, reload 0
    wr(3'd5, 8'h00); wr(3'd1, 8'h00); wr(3'd0, 8'h02);
    tick();
    rd("os_en_off", 3'd0, 8'h00, 1'b0, 2'd0);
    rd("os_pend", 3'd2, 8'h02, 1'b0, 2'd0);
    tick();
    rd("os_t2", 3'd2, 8'h02, 1'b0, 2'd0);

    // Channels 0 and 2 together; masked ack; priority and ack sequencing
    wr(3'd2, 8'hFF); wr(3'd4, 8'd1); wr(3'd6, 8'd1); wr(3'd3, 8'h00); wr(3'd0, 8'h05);
    tick();
    rd("pri_t1", 3'd2, 8'h00, 1'b0, 2'd0);
    tick();
    rd("pri_en", 3'd0, 8'h00, 1'b0, 2'd0);
    rd("pri_masked", 3'd2, 8'h05, 1'b0, 2'd0);
    ack();
    rd("ack_no_irq", 3'd2, 8'h05, 1'b0, 2'd0);
    wr(3'd3, 8'h05);
    rd("pri_id0", 3'd3, 8'h05, 1'b1, 2'd0);
    ack();
    rd("pri_id2", 3'd2, 8'h04, 1'b1, 2'd2);
    ack();
    rd("pri_done", 3'd2, 8'h00, 1'b0, 2'd0);

    // Same-cycle collisions on channel 0 (periodic, reload 0)
    wr(3'd2, 8'hFF); wr(3'd4, 8'd0); wr(3'd1, 8'h01); wr(3'd3, 8'h01);
    cyc(1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0);
    rd("en_tick_load", 3'd2, 8'h00, 1'b0, 2'd0);
    tick();
    rd("first_exp", 3'd2, 8'h01, 1'b1, 2'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    rd("exp_vs_ack", 3'd2, 8'h11, 1'b1, 2'd0);
    cyc(1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 1'b0);
    rd("exp_vs_w1c", 3'd2, 8'h11, 1'b1, 2'd0);
    wr(3'd2, 8'hFF);
    rd("w1c_all", 3'd2, 8'h00, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0);
    rd("dis_vs_exp_en", 3'd0, 8'h00, 1'b1, 2'd0);
    rd("dis_vs_exp_pend", 3'd2, 8'h01, 1'b1, 2'd0);
    ack();
    tick();
    rd("frozen", 3'd2, 8'h00, 1'b0, 2'd0);
    expect_rd("wr_during_rd", 8'h01, 1'b0, 2'd0);
    cyc(1'b1, 1'b1, 3'd3, 8'hFF, 1'b0, 1'b0);
    rd("wr_ignored", 3'd3, 8'h01, 1'b0, 2'd0);

    // Prescaler (or its absence)
    wr(3'd3, 8'hF1);
    rd("imask_f1", 3'd3, IMASK_F1, 1'b0, 2'd0);
    wr(3'd1, 8'h00); wr(3'd2, 8'hFF); wr(3'd4, 8'd1); wr(3'd3, 8'h21);
    rd("imask_21", 3'd3, IMASK_21, 1'b0, 2'd0);
    wr(3'd0, 8'h01);
    for (int i = 1; i <= 6; i++) begin
      tick();
      rd($sformatf("psc_t%0d", i), 3'd2, (i >= FIRST_EXP) ? 8'h01 : 8'h00, i >= FIRST_EXP, 2'd0);
    end

    // Reset while counting, with a tick in the reset cycle
    wr(3'd1, 8'h01); wr(3'd0, 8'h01); tick();
    rst = 1'b0; bus.tick = 1'b1;
    @(posedge clk); #1;
    bus.tick = 1'b0; rst = 1'b1;
    for (int i = 0; i < 8; i++) rd($sformatf("rst2_reg%0d", i), 3'(i), reset_vals[i], 1'b0, 2'd0);

    repeat (3) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
